pcs_reset_ctrl: RTL and testbench

PCS_RESET_CTRL -- requirements
Module: pcs_reset_ctrl

---
 rtl/pcs_pkg.sv | 31 +++
 rtl/ctrl_timer.sv | 26 ++
 rtl/pcs_reset_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_pcs_reset_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcs_pkg.sv
// Shared state encoding, default sequencing constants and small helpers
// for the PCS reset controller.
package pcs_pkg;

  typedef enum logic [2:0] {
    WAIT_XVER = 3'd0,
    TX_HOLD   = 3'd1,
    RX_HOLD   = 3'd2,
    WAIT_LOCK = 3'd3,
    LINKED    = 3'd4,
    RX_RETRY  = 3'd5,
    RX_WAIT   = 3'd6
  } pcs_state_e;

  localparam int HOLD_CYCLES_DEF  = 16;
  localparam int LOCK_TIMEOUT_DEF = 65536;
  localparam int REQ_CYCLES_DEF   = 4;

  localparam logic [7:0] RETRY_MAX = 8'hFF;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == RETRY_MAX) ? v : v + 8'd1;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ctrl_timer.sv
// Loadable down-counter; stops at zero and flags expiry while it sits there.
module ctrl_timer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             expired
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (count_q != '0) begin
      count_q <= count_q - WIDTH'(1);
    end
  end

  assign expired = (count_q == '0);

endmodule

// File: rtl/pcs_reset_ctrl.sv
// PCS reset sequencer: releases tx then rx, waits for block lock, retries rx on lock timeout.
// Build macro PCS_HIBER_RETRY_EN: hi_ber in WAIT_LOCK or LINKED forces an immediate rx retry.
//
// state     | meaning
// WAIT_XVER | transceiver not ready; tx and rx PCS resets held
// TX_HOLD   | both transceiver paths ready; holding tx reset HOLD_CYCLES
// RX_HOLD   | tx released; holding rx reset HOLD_CYCLES
// WAIT_LOCK | rx released; waiting up to LOCK_TIMEOUT for block lock
// LINKED    | block lock held; link_up asserted
// RX_RETRY  | pulsing xver_rx_reset_req for REQ_CYCLES, rx reset held
// RX_WAIT   | waiting for transceiver rx reset to complete
module pcs_reset_ctrl
  import pcs_pkg::*;
#(
  parameter int HOLD_CYCLES  = HOLD_CYCLES_DEF,
  parameter int LOCK_TIMEOUT = LOCK_TIMEOUT_DEF,
  parameter int REQ_CYCLES   = REQ_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       xver_tx_reset_done,
  input  logic       xver_rx_reset_done,
  input  logic       block_lock,
  input  logic       hi_ber,
  output logic       tx_reset,
  output logic       rx_reset,
  output logic       xver_rx_reset_req,
  output logic       link_up,
  output logic [7:0] retry_count,
  output logic [2:0] state
);

  localparam int MAX_LOAD = max3(HOLD_CYCLES, LOCK_TIMEOUT, REQ_CYCLES);
  localparam int TW       = (MAX_LOAD > 1) ? $clog2(MAX_LOAD) : 1;

  // Loading N-1 makes the exit edge land exactly N edges after entry.
  localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] LOCK_LOAD = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] REQ_LOAD  = TW'(REQ_CYCLES - 1);

  pcs_state_e    state_q, state_d;
  logic          tx_q, tx_d;
  logic          rx_q, rx_d;
  logic          req_q, req_d;
  logic          link_q, link_d;
  logic [7:0]    retry_q, retry_d;
  logic          go_retry;
  logic          tmr_load;
  logic [TW-1:0] tmr_val;
  logic          tmr_expired;

`ifndef PCS_HIBER_RETRY_EN
  logic hi_ber_unused;
  assign hi_ber_unused = hi_ber;
`endif

  ctrl_timer #(.WIDTH(TW)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .load    (tmr_load),
    .load_val(tmr_val),
    .expired (tmr_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= WAIT_XVER;
      tx_q    <= 1'b1;
      rx_q    <= 1'b1;
      req_q   <= 1'b0;
      link_q  <= 1'b0;
      retry_q <= '0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      req_q   <= req_d;
      link_q  <= link_d;
      retry_q <= retry_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    req_d    = 1'b0;
    link_d   = link_q;
    retry_d  = retry_q;
    go_retry = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = '0;

    // Loss of the tx path outranks everything, including same-edge lock changes.
    if (state_q != WAIT_XVER && !xver_tx_reset_done) begin
      state_d = WAIT_XVER;
      tx_d    = 1'b1;
      rx_d    = 1'b1;
      link_d  = 1'b0;
    end else if ((state_q == RX_HOLD || state_q == WAIT_LOCK || state_q == LINKED) &&
                 !xver_rx_reset_done) begin
      state_d = RX_WAIT;
      rx_d    = 1'b1;
      link_d  = 1'b0;
`ifdef PCS_HIBER_RETRY_EN
    end else if ((state_q == WAIT_LOCK || state_q == LINKED) && hi_ber) begin
      go_retry = 1'b1;
`endif
    end else begin
      case (state_q)
        WAIT_XVER: begin
          tx_d   = 1'b1;
          rx_d   = 1'b1;
          link_d = 1'b0;
          if (xver_tx_reset_done && xver_rx_reset_done) begin
            state_d  = TX_HOLD;
            tmr_load = 1'b1;
            tmr_val  = HOLD_LOAD;
          end
        end
        TX_HOLD: begin
          if (tmr_expired) begin
            state_d  = RX_HOLD;
            tx_d     = 1'b0;
            tmr_load = 1'b1;
            tmr_val  = HOLD_LOAD;
          end
        end
        RX_HOLD: begin
          if (tmr_expired) begin
            state_d  = WAIT_LOCK;
            rx_d     = 1'b0;
            tmr_load = 1'b1;
            tmr_val  = LOCK_LOAD;
          end
        end
        WAIT_LOCK: begin
          if (block_lock) begin
            state_d = LINKED;
            link_d  = 1'b1;
          end else if (tmr_expired) begin
            go_retry = 1'b1;
          end
        end
        LINKED: begin
          if (!block_lock) begin
            state_d  = WAIT_LOCK;
            link_d   = 1'b0;
            tmr_load = 1'b1;
            tmr_val  = LOCK_LOAD;
          end
        end
        RX_RETRY: begin
          if (tmr_expired) begin
            state_d = RX_WAIT;
          end else begin
            req_d = 1'b1;
          end
        end
        RX_WAIT: begin
          if (xver_rx_reset_done) begin
            state_d  = RX_HOLD;
            tmr_load = 1'b1;
            tmr_val  = HOLD_LOAD;
          end
        end
        default: begin
          state_d = WAIT_XVER;
          tx_d    = 1'b1;
          rx_d    = 1'b1;
          link_d  = 1'b0;
        end
      endcase
    end

    if (go_retry) begin
      state_d  = RX_RETRY;
      rx_d     = 1'b1;
      link_d   = 1'b0;
      req_d    = 1'b1;
      retry_d  = sat_inc8(retry_q);
      tmr_load = 1'b1;
      tmr_val  = REQ_LOAD;
    end
  end

  assign tx_reset          = tx_q;
  assign rx_reset          = rx_q;
  assign xver_rx_reset_req = req_q;
  assign link_up           = link_q;
  assign retry_count       = retry_q;
  assign state             = state_q;

endmodule

// File: tb/tb_pcs_reset_ctrl.sv
// Directed-sequence bench for pcs_reset_ctrl with randomized timing; expected
// outputs come from cycle arithmetic on the sequencing rules.
module tb_pcs_reset_ctrl;

  localparam int HOLD = 4;
  localparam int LOCK = 100;
  localparam int REQ  = 3;

  localparam int S_WAIT_XVER = 0;
  localparam int S_TX_HOLD   = 1;
  localparam int S_RX_HOLD   = 2;
  localparam int S_WAIT_LOCK = 3;
  localparam int S_LINKED    = 4;
  localparam int S_RX_RETRY  = 5;
  localparam int S_RX_WAIT   = 6;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       xver_tx_reset_done = 1'b0;
  logic       xver_rx_reset_done = 1'b0;
  logic       block_lock = 1'b0;
  logic       hi_ber = 1'b0;
  logic       tx_reset;
  logic       rx_reset;
  logic       xver_rx_reset_req;
  logic       link_up;
  logic [7:0] retry_count;
  logic [2:0] state;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  int cyc     = 0;

  int e_state = S_WAIT_XVER;
  bit e_tx    = 1'b1;
  bit e_rx    = 1'b1;
  bit e_req   = 1'b0;
  bit e_link  = 1'b0;
  int e_retry = 0;
  bit hiber_noise = 1'b0;

  always #5 clk = ~clk;

  pcs_reset_ctrl #(
    .HOLD_CYCLES (HOLD),
    .LOCK_TIMEOUT(LOCK),
    .REQ_CYCLES  (REQ)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .xver_tx_reset_done(xver_tx_reset_done),
    .xver_rx_reset_done(xver_rx_reset_done),
    .block_lock        (block_lock),
    .hi_ber            (hi_ber),
    .tx_reset          (tx_reset),
    .rx_reset          (rx_reset),
    .xver_rx_reset_req (xver_rx_reset_req),
    .link_up           (link_up),
    .retry_count       (retry_count),
    .state             (state)
  );

  function automatic int sat(input int v);
    return (v >= 255) ? 255 : v + 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %0d required %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, " state"}, 32'(state), 32'(e_state));
    chk({tag, " tx_reset"}, 32'(tx_reset), 32'(e_tx));
    chk({tag, " rx_reset"}, 32'(rx_reset), 32'(e_rx));
    chk({tag, " xver_rx_reset_req"}, 32'(xver_rx_reset_req), 32'(e_req));
    chk({tag, " link_up"}, 32'(link_up), 32'(e_link));
    chk({tag, " retry_count"}, 32'(retry_count), 32'(e_retry));
  endtask

  task automatic set_exp(input int st, input bit tx, input bit rx, input bit req, input bit link);
    e_state = st;
    e_tx    = tx;
    e_rx    = rx;
    e_req   = req;
    e_link  = link;
  endtask

  // One clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    if (hiber_noise) hi_ber = 1'($urandom_range(0, 1));
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) begin
      step();
      e_retry = 0;
      set_exp(S_WAIT_XVER, 1'b1, 1'b1, 1'b0, 1'b0);
      check_all("reset");
    end
    reset = 1'b0;
    cyc   = 0;
  endtask

  // Both done inputs are first sampled high on edge first_edge.
  task automatic bring_up(input int first_edge);
    int tx_fall;
    int rx_fall;
    int p;
    tx_fall = -1;
    rx_fall = -1;
    block_lock = 1'b0;
    while (cyc < first_edge - 1) begin
      p = int'($urandom_range(0, 2));
      xver_tx_reset_done = (p == 1);
      xver_rx_reset_done = (p == 2);
      step();
      set_exp(S_WAIT_XVER, 1'b1, 1'b1, 1'b0, 1'b0);
      check_all("wait_xver");
    end
    xver_tx_reset_done = 1'b1;
    xver_rx_reset_done = 1'b1;
    for (int n = first_edge; n <= first_edge + 2 * HOLD; n++) begin
      step();
      if (tx_reset === 1'b0 && tx_fall < 0) tx_fall = cyc;
      if (rx_reset === 1'b0 && rx_fall < 0) rx_fall = cyc;
      if (n < first_edge + HOLD) set_exp(S_TX_HOLD, 1'b1, 1'b1, 1'b0, 1'b0);
      else if (n < first_edge + 2 * HOLD) set_exp(S_RX_HOLD, 1'b0, 1'b1, 1'b0, 1'b0);
      else set_exp(S_WAIT_LOCK, 1'b0, 1'b0, 1'b0, 1'b0);
      check_all("bring_up");
    end
    chk("tx_fall_cycle", tx_fall, first_edge + HOLD);
    chk("rx_fall_cycle", rx_fall, first_edge + 2 * HOLD);
  endtask

  // block_lock first sampled high L edges after entering WAIT_LOCK.
  task automatic lock_after(input int L);
    for (int j = 1; j <= L; j++) begin
      if (j == L) block_lock = 1'b1;
      step();
      if (j < L) set_exp(S_WAIT_LOCK, 1'b0, 1'b0, 1'b0, 1'b0);
      else set_exp(S_LINKED, 1'b0, 1'b0, 1'b0, 1'b1);
      check_all("lock_after");
    end
  endtask

  task automatic drop_lock();
    block_lock = 1'b0;
    step();
    set_exp(S_WAIT_LOCK, 1'b0, 1'b0, 1'b0, 1'b0);
    check_all("lock_drop");
  endtask

  task automatic timeout();
    block_lock = 1'b0;
    for (int j = 1; j <= LOCK; j++) begin
      step();
      if (j < LOCK) begin
        set_exp(S_WAIT_LOCK, 1'b0, 1'b0, 1'b0, 1'b0);
      end else begin
        e_retry = sat(e_retry);
        set_exp(S_RX_RETRY, 1'b0, 1'b1, 1'b1, 1'b0);
      end
      check_all("timeout");
    end
  endtask

  task automatic rx_recover(input int w);
    xver_rx_reset_done = 1'b0;
    for (int i = 0; i < w; i++) begin
      step();
      set_exp(S_RX_WAIT, 1'b0, 1'b1, 1'b0, 1'b0);
      check_all("rx_wait");
    end
    xver_rx_reset_done = 1'b1;
    for (int n = 1; n <= HOLD + 1; n++) begin
      step();
      if (n <= HOLD) set_exp(S_RX_HOLD, 1'b0, 1'b1, 1'b0, 1'b0);
      else set_exp(S_WAIT_LOCK, 1'b0, 1'b0, 1'b0, 1'b0);
      check_all("rx_recover");
    end
  endtask

  // Entered RX_RETRY one edge ago; rx_done wiggles here and must be ignored.
  task automatic retry_recover();
    for (int j = 1; j <= REQ; j++) begin
      xver_rx_reset_done = 1'($urandom_range(0, 1));
      step();
      if (j < REQ) set_exp(S_RX_RETRY, 1'b0, 1'b1, 1'b1, 1'b0);
      else set_exp(S_RX_WAIT, 1'b0, 1'b1, 1'b0, 1'b0);
      check_all("retry_pulse");
    end
    rx_recover(int'($urandom_range(0, 4)));
  endtask

  initial begin
`ifndef PCS_HIBER_RETRY_EN
    hiber_noise = 1'b1;
`endif
    do_reset(3);
    bring_up(10);
    lock_after(20);
    repeat (5) begin
      step();
      check_all("linked_hold");
    end

    drop_lock();
    lock_after(LOCK - 1);
    repeat (3) begin
      drop_lock();
      lock_after(int'($urandom_range(1, LOCK - 1)));
    end

    hiber_noise = 1'b0;
    hi_ber = 1'b1;
`ifdef PCS_HIBER_RETRY_EN
    step();
    e_retry = sat(e_retry);
    set_exp(S_RX_RETRY, 1'b0, 1'b1, 1'b1, 1'b0);
    check_all("hiber_retry");
    hi_ber = 1'b0;
    block_lock = 1'b0;
    retry_recover();
    lock_after(int'($urandom_range(1, LOCK - 1)));
`else
    repeat (5) begin
      step();
      check_all("hiber_ignored");
    end
    hi_ber = 1'b0;
    hiber_noise = 1'b1;
`endif

    xver_rx_reset_done = 1'b0;
    step();
    set_exp(S_RX_WAIT, 1'b0, 1'b1, 1'b0, 1'b0);
    check_all("rx_drop");
    block_lock = 1'b0;
    rx_recover(int'($urandom_range(0, 5)));
    lock_after(int'($urandom_range(1, LOCK - 1)));

    drop_lock();
    repeat (300) begin
      timeout();
      retry_recover();
    end
    chk("retry_saturated", 32'(retry_count), 32'd255);

    lock_after(7);
    xver_tx_reset_done = 1'b0;
    xver_rx_reset_done = 1'b0;
    block_lock = 1'b0;
    step();
    set_exp(S_WAIT_XVER, 1'b1, 1'b1, 1'b0, 1'b0);
    check_all("tx_drop");

    bring_up(cyc + int'($urandom_range(2, 6)));
    timeout();
    step();
    set_exp(S_RX_RETRY, 1'b0, 1'b1, 1'b1, 1'b0);
    check_all("retry_mid_pulse");
    do_reset(1);

    bring_up(5);
    lock_after(1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
